// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue controller for the iterative multiply/divide units: latches the
// request, runs the start/annul handshake, stalls EX and writes the result to HI/LO.
//
// Handshake: start_o rises on issue and stays high until the selected unit's ready
// is sampled (or the op is flushed/aborted); the unit must drop ready once start_o
// falls. annul_o is a one-cycle pulse; hilo_we_o is a one-cycle pulse with hi_o/lo_o.
module muldiv_issue_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        start_o,
    output logic        annul_o,
    output logic        signed_o,
    output logic [31:0] opdata1_o,
    output logic [31:0] opdata2_o,
    output logic        mul_sel_o,
    input  logic        mul_ready_i,
    input  logic [63:0] mul_result_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;
    logic             start_q, start_d;
    logic             annul_q, annul_d;
    logic             signed_q, signed_d;
    logic             sel_q, sel_d;
    logic             we_q, we_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      d1_q, d1_d;
    logic [31:0]      d2_q, d2_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             issue;
    logic             unit_ready;
    logic [63:0]      unit_result;

    // Gated by rst so that stallreq_o reads 0 while the block is held in reset.
    assign issue       = rst && (state_q == ST_IDLE) && op_valid_i && !flush_i;
    assign unit_ready  = sel_q ? mul_ready_i  : div_ready_i;
    assign unit_result = sel_q ? mul_result_i : div_result_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        start_d   = start_q;
        annul_d   = 1'b0;
        signed_d  = signed_q;
        sel_d     = sel_q;
        we_d      = 1'b0;
        timeout_d = timeout_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    d1_d     = src1_i;
                    d2_d     = src2_i;
                    signed_d = ~op_i[0];
                    sel_d    = ~op_i[1];
                    start_d  = 1'b1;
                    stall_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Flush beats a same-cycle ready: the killed instruction must not write HI/LO.
                if (flush_i) begin
                    annul_d = 1'b1;
                    start_d = 1'b0;
                    stall_d = 1'b0;
                    state_d = ST_RELEASE;
                end else if (unit_ready) begin
                    hi_d    = unit_result[63:32];
                    lo_d    = unit_result[31:0];
                    start_d = 1'b0;
                    stall_d = 1'b0;
                    we_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    annul_d   = 1'b1;
                    start_d   = 1'b0;
                    stall_d   = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_RELEASE: begin
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
            signed_q  <= 1'b0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
            d1_q      <= '0;
            d2_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            start_q   <= start_d;
            annul_q   <= annul_d;
            signed_q  <= signed_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            timeout_q <= timeout_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign stallreq_o = stall_q | issue;
    assign start_o    = start_q;
    assign annul_o    = annul_q;
    assign signed_o   = signed_q;
    assign mul_sel_o  = sel_q;
    assign opdata1_o  = d1_q;
    assign opdata2_o  = d2_q;
    assign hilo_we_o  = we_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign timeout_o  = timeout_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: a pipeline/unit driver plus an arithmetic reference
// model for HI/LO, stall length, handshake pulses and watchdog behaviour.
module tb_muldiv_issue_ctrl;

    localparam int TIMEOUT = 40;
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        op_valid_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] src1_i = '0, src2_i = '0;
    logic        flush_i = 1'b0;
    logic        mul_ready_i = 1'b0, div_ready_i = 1'b0;
    logic [63:0] mul_result_i = '0, div_result_i = '0;
    logic        stallreq_o, start_o, annul_o, signed_o, mul_sel_o, hilo_we_o, timeout_o;
    logic [31:0] opdata1_o, opdata2_o, hi_o, lo_o;
    logic [1:0]  state_dbg;

    muldiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
        .stallreq_o(stallreq_o), .start_o(start_o), .annul_o(annul_o),
        .signed_o(signed_o), .opdata1_o(opdata1_o), .opdata2_o(opdata2_o),
        .mul_sel_o(mul_sel_o), .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o),
        .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    // rdy_at: WAIT cycle in which the unit answers (0 = never)
    // flush_at: WAIT cycle to flush (>0), -1 flush when presented, -2 flush in DONE, 0 none
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          rdy_at;
        int          flush_at;
        int          rst_at;
        int          delay;
    } op_t;

    op_t         seq_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_stall, n_start_cyc, n_annul, n_rises, gap_min, stable_err, t_first;
    logic        obs_signed, obs_sel, hung, rst_zero_ok;
    logic [31:0] obs_d1, obs_d2;

    function automatic op_t mk_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int rdy_at, input int flush_at, input int rst_at, input int delay);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.rdy_at = rdy_at;
        o.flush_at = flush_at; o.rst_at = rst_at; o.delay = delay;
        return o;
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV:   return {32'(ia % ib), 32'(ia / ib)};
            default:  return {a % b, a / b};
        endcase
    endfunction

    function automatic op_t rand_op(input int rdy_max, input int delay);
        op_t o;
        o = mk_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(1, rdy_max), 0, 0, delay);
        if (o.b == 32'd0) o.b = 32'd1;
        if (o.op == OP_DIV && o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF) o.b = 32'd3;
        return o;
    endfunction

    // ---------------- driver: pipeline EX slot + both units ----------------
    task automatic run_seq();
        int   idx = 0, pend, wait_n = 0, last_wait = 0, low_run = 0, cyc = 0, tail = 0;
        logic in_ex = 1'b0, prev_start = 1'b0, stall_now, killed, check_zero = 1'b0;
        op_t  cur;
        got_q.delete();
        n_stall = 0; n_start_cyc = 0; n_annul = 0; n_rises = 0; gap_min = 1000;
        stable_err = 0; t_first = -1; hung = 1'b0; rst_zero_ok = 1'b0;
        cur = seq_q[0];
        pend = seq_q[0].delay;
        if (pend == 0) begin
            in_ex = 1'b1; op_valid_i = 1'b1; op_i = cur.op; src1_i = cur.a; src2_i = cur.b;
        end
        while (1) begin
            if (cur.op[1] == 1'b0) begin
                mul_ready_i  = (cur.rdy_at > 0) && (wait_n >= cur.rdy_at);
                mul_result_i = mul_ready_i ? ref_result(cur.op, cur.a, cur.b) : {$urandom, $urandom};
                div_ready_i  = 1'($urandom_range(0, 1));
                div_result_i = {$urandom, $urandom};
            end else begin
                div_ready_i  = (cur.rdy_at > 0) && (wait_n >= cur.rdy_at);
                div_result_i = div_ready_i ? ref_result(cur.op, cur.a, cur.b) : {$urandom, $urandom};
                mul_ready_i  = 1'($urandom_range(0, 1));
                mul_result_i = {$urandom, $urandom};
            end
            flush_i = in_ex && ((cur.flush_at > 0 && wait_n == cur.flush_at) ||
                                (cur.flush_at == -1 && wait_n == 0) ||
                                (cur.flush_at == -2 && wait_n == 0 && last_wait > 0 && last_wait == cur.rdy_at));
            rst = !(in_ex && cur.rst_at > 0 && wait_n == cur.rst_at);
            @(negedge clk);
            if (check_zero) begin
                rst_zero_ok = ({stallreq_o, start_o, annul_o, signed_o, mul_sel_o, hilo_we_o, timeout_o} == 7'd0) &&
                              ({opdata1_o, opdata2_o, hi_o, lo_o} == 128'd0) && (state_dbg == 2'd0);
                check_zero = 1'b0;
            end
            if (!rst) check_zero = 1'b1;
            if (stallreq_o) n_stall++;
            if (start_o) n_start_cyc++;
            if (annul_o) n_annul++;
            if (timeout_o && t_first < 0) t_first = n_start_cyc;
            if (start_o && !prev_start) begin
                n_rises++;
                if (n_rises > 1 && low_run < gap_min) gap_min = low_run;
                low_run = 0;
            end
            if (!start_o) low_run++;
            prev_start = start_o;
            if (hilo_we_o) got_q.push_back({hi_o, lo_o});
            if (start_o && wait_n == 1) begin
                obs_signed = signed_o; obs_sel = mul_sel_o; obs_d1 = opdata1_o; obs_d2 = opdata2_o;
            end
            if (start_o && wait_n > 1 &&
                (signed_o !== obs_signed || mul_sel_o !== obs_sel || opdata1_o !== obs_d1 || opdata2_o !== obs_d2))
                stable_err++;
            stall_now = stallreq_o;
            killed = flush_i || !rst;
            @(posedge clk); #1;
            cyc++;
            rst = 1'b1;
            flush_i = 1'b0;
            last_wait = wait_n;
            wait_n = start_o ? wait_n + 1 : 0;
            if (in_ex && (!stall_now || killed)) begin
                in_ex = 1'b0; op_valid_i = 1'b0; idx++;
                if (idx < seq_q.size()) pend = seq_q[idx].delay;
            end else if (!in_ex && idx < seq_q.size() && pend > 0) begin
                pend--;
            end
            if (!in_ex && idx < seq_q.size() && pend == 0) begin
                cur = seq_q[idx];
                in_ex = 1'b1; op_valid_i = 1'b1; op_i = cur.op; src1_i = cur.a; src2_i = cur.b;
            end
            if (!in_ex && idx >= seq_q.size()) begin
                tail++;
                if (tail >= 4) break;
            end
            if (cyc >= 400) begin
                hung = 1'b1;
                break;
            end
        end
        op_valid_i = 1'b0; flush_i = 1'b0; mul_ready_i = 1'b0; div_ready_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        op_valid_i = 1'b1; src1_i = $urandom; src2_i = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
        checks++; if ({start_o, annul_o, signed_o, mul_sel_o} !== 4'd0) begin errors++; $display("FAIL reset_hs got=%b exp=0000", {start_o, annul_o, signed_o, mul_sel_o}); end
        checks++; if ({hilo_we_o, timeout_o} !== 2'd0) begin errors++; $display("FAIL reset_we_to got=%b exp=00", {hilo_we_o, timeout_o}); end
        checks++; if ({opdata1_o, opdata2_o, hi_o, lo_o} !== 128'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {opdata1_o, opdata2_o, hi_o, lo_o}); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        @(posedge clk); #1;
        op_valid_i = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_mult_neg();
        seq_q = '{mk_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 34, 0, 0, 0)};
        run_seq();
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL mult_hung got=%b exp=0", hung); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mult_we_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_hilo got=%h exp=ffffffff_fffffffa", got_q[0]); end
        end
        checks++; if (n_stall != 35) begin errors++; $display("FAIL mult_stall got=%0d exp=35", n_stall); end
        checks++; if ({obs_signed, obs_sel} !== 2'b11) begin errors++; $display("FAIL mult_sign_sel got=%b exp=11", {obs_signed, obs_sel}); end
        checks++; if ({obs_d1, obs_d2} !== {32'hFFFF_FFFE, 32'd3}) begin errors++; $display("FAIL mult_opdata got=%h exp=fffffffe00000003", {obs_d1, obs_d2}); end
        checks++; if (n_start_cyc != 34 || n_annul != 0 || stable_err != 0) begin
            errors++; $display("FAIL mult_hs got start=%0d annul=%0d unstable=%0d exp 34/0/0", n_start_cyc, n_annul, stable_err);
        end
    endtask

    task automatic test_divu();
        seq_q = '{mk_op(OP_DIVU, 32'd100, 32'd7, 20, 0, 0, 0)};
        run_seq();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL divu_we_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hilo got=%h exp=00000002_0000000e", got_q[0]); end
        end
        checks++; if ({obs_signed, obs_sel} !== 2'b00) begin errors++; $display("FAIL divu_sign_sel got=%b exp=00", {obs_signed, obs_sel}); end
        checks++; if (n_rises != 1) begin errors++; $display("FAIL divu_no_reissue got=%0d starts exp=1", n_rises); end
        checks++; if (n_stall != 21) begin errors++; $display("FAIL divu_stall got=%0d exp=21", n_stall); end
    endtask

    task automatic test_random_ops();
        op_t o;
        logic [63:0] e;
        for (int i = 0; i < 12; i++) begin
            o = rand_op(34, 0);
            e = ref_result(o.op, o.a, o.b);
            seq_q = '{o};
            run_seq();
            checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rand%0d_we_count got=%0d exp=1", i, got_q.size()); end
            else begin
                checks++; if (got_q[0] !== e) begin errors++; $display("FAIL rand%0d_hilo op=%0d got=%h exp=%h", i, o.op, got_q[0], e); end
            end
            checks++; if (n_stall != 1 + o.rdy_at) begin errors++; $display("FAIL rand%0d_stall got=%0d exp=%0d", i, n_stall, 1 + o.rdy_at); end
            checks++; if ({obs_signed, obs_sel} !== {~o.op[0], ~o.op[1]}) begin errors++; $display("FAIL rand%0d_sign_sel got=%b exp=%b", i, {obs_signed, obs_sel}, {~o.op[0], ~o.op[1]}); end
            checks++; if ({obs_d1, obs_d2} !== {o.a, o.b}) begin errors++; $display("FAIL rand%0d_opdata got=%h exp=%h", i, {obs_d1, obs_d2}, {o.a, o.b}); end
            checks++; if (stable_err != 0 || n_rises != 1) begin errors++; $display("FAIL rand%0d_hs got unstable=%0d starts=%0d exp 0/1", i, stable_err, n_rises); end
        end
    endtask

    task automatic test_flush_wait();
        op_t o1, o2;
        o1 = mk_op(OP_MULTU, $urandom, $urandom, 30, 10, 0, 0);
        o2 = mk_op(OP_MULT, $urandom, $urandom, 6, 0, 0, 2);
        seq_q = '{o1, o2};
        exp_q = '{ref_result(o2.op, o2.a, o2.b)};
        run_seq();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_we_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_next_hilo got=%h exp=%h", got_q[0], exp_q[0]); end
        end
        checks++; if (n_annul != 1) begin errors++; $display("FAIL flush_annul got=%0d cycles exp=1", n_annul); end
        checks++; if (n_rises != 2 || n_start_cyc != 16) begin errors++; $display("FAIL flush_starts got rises=%0d cyc=%0d exp 2/16", n_rises, n_start_cyc); end
        checks++; if (n_stall != 18) begin errors++; $display("FAIL flush_stall got=%0d exp=18", n_stall); end
    endtask

    task automatic test_ready_flush();
        seq_q = '{mk_op(OP_DIV, $urandom, 32'd5, 7, 7, 0, 0)};
        run_seq();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rdyflush_we got=%0d exp=0", got_q.size()); end
        checks++; if (n_annul != 1 || n_stall != 8) begin errors++; $display("FAIL rdyflush_hs got annul=%0d stall=%0d exp 1/8", n_annul, n_stall); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rdyflush_idle got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_flush_idle_done();
        op_t o2;
        o2 = mk_op(OP_MULT, $urandom, $urandom, 4, -2, 0, 1);
        seq_q = '{mk_op(OP_MULTU, $urandom, $urandom, 3, -1, 0, 0), o2};
        run_seq();
        checks++; if (n_rises != 1 || n_annul != 0) begin errors++; $display("FAIL flushidle_issue got rises=%0d annul=%0d exp 1/0", n_rises, n_annul); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL flushdone_we got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ref_result(o2.op, o2.a, o2.b)) begin errors++; $display("FAIL flushdone_hilo got=%h exp=%h", got_q[0], ref_result(o2.op, o2.a, o2.b)); end
        end
        checks++; if (n_stall != 5) begin errors++; $display("FAIL flushidle_stall got=%0d exp=5", n_stall); end
    endtask

    task automatic test_timeout();
        op_t o2;
        o2 = mk_op(OP_MULTU, $urandom, $urandom, 3, 0, 0, 0);
        seq_q = '{mk_op(OP_DIVU, $urandom, 32'd9, 0, 0, 0, 0), o2};
        run_seq();
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL tmo_hung got=%b exp=0", hung); end
        checks++; if (t_first != TIMEOUT) begin errors++; $display("FAIL tmo_when got=%0d wait cycles exp=%0d", t_first, TIMEOUT); end
        checks++; if (n_annul != 1 || n_stall != TIMEOUT + 1 + 4) begin errors++; $display("FAIL tmo_hs got annul=%0d stall=%0d exp 1/%0d", n_annul, n_stall, TIMEOUT + 5); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL tmo_we got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ref_result(o2.op, o2.a, o2.b)) begin errors++; $display("FAIL tmo_next_hilo got=%h exp=%h", got_q[0], ref_result(o2.op, o2.a, o2.b)); end
        end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", timeout_o); end
    endtask

    task automatic test_reset_mid();
        op_t o2;
        o2 = mk_op(OP_MULT, $urandom, $urandom, 3, 0, 0, 1);
        seq_q = '{mk_op(OP_MULT, $urandom, $urandom, 20, 0, 5, 0), o2};
        run_seq();
        checks++; if (rst_zero_ok !== 1'b1) begin errors++; $display("FAIL rstmid_zero got=%b exp=1", rst_zero_ok); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_we got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ref_result(o2.op, o2.a, o2.b)) begin errors++; $display("FAIL rstmid_hilo got=%h exp=%h", got_q[0], ref_result(o2.op, o2.a, o2.b)); end
        end
        checks++; if (n_stall != 10 || n_annul != 0) begin errors++; $display("FAIL rstmid_hs got stall=%0d annul=%0d exp 10/0", n_stall, n_annul); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rstmid_tmo_clear got=%b exp=0", timeout_o); end
    endtask

    task automatic test_back_to_back();
        op_t o;
        seq_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            o = rand_op(10, 0);
            seq_q.push_back(o);
            exp_q.push_back(ref_result(o.op, o.a, o.b));
        end
        run_seq();
        checks++; if (n_rises != 4 || gap_min != 2) begin errors++; $display("FAIL b2b_gap got rises=%0d gap=%0d exp 4/2", n_rises, gap_min); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_we_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_hilo%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mult_neg();
        test_divu();
        test_random_ops();
        test_flush_wait();
        test_ready_flush();
        test_flush_idle_done();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
EX-stage initiator for the iterative multiply/divide units. It latches a MULT/MULTU/DIV/DIVU request and drives the start/annul/signed handshake to the selected unit. While the operation runs it holds the pipeline stalled, then captures the 64-bit result and writes it to HI/LO. It handles flushes, handshake release and a watchdog timeout.

Parameters:
TIMEOUT, 40, max cycles in a WAIT state before abort (must be > 34; a 32-bit iterative op takes ≤34)
CNT_W, 6, width of the watchdog counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
op_valid_i  in  1  EX holds a mul/div instruction
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1_i  in  32  rs operand
src2_i  in  32  rt operand
flush_i  in  1  pipeline flush (exception/branch kill)
stallreq_o  out  1  request EX stall
start_o  out  1  start to unit (held until ready, then dropped)
annul_o  out  1  cancel running op (1-cycle pulse)
signed_o  out  1  signed operation
opdata1_o  out  32  latched src1
opdata2_o  out  32  latched src2
mul_sel_o  out  1  1 = multiplier is target, 0 = divider
mul_ready_i  in  1  multiplier result valid
mul_result_i  in  64  {hi,lo} product
div_ready_i  in  1  divider result valid
div_result_i  in  64  {remainder,quotient}
hilo_we_o  out  1  HI/LO write enable (1-cycle pulse)
hi_o  out  32  value for HI
lo_o  out  32  value for LO
timeout_o  out  1  sticky watchdog error

Behaviour:
- All outputs are registered. While rst=0 every output is 0, state=IDLE, counter=0, timeout_o=0.
- States: IDLE, WAIT, DONE, RELEASE.
- IDLE:
  - op_valid_i=1 and flush_i=0 → latch src1/src2 to opdata*_o.
  - signed_o = ~op_i[0]; mul_sel_o = ~op_i[1].
  - start_o<=1, stallreq_o<=1, counter<=0, go WAIT.
  - stallreq_o must be asserted combinationally in this same cycle (stallreq_o = registered_stall | (state==IDLE & op_valid_i & ~flush_i)) so the instruction does not leave EX.
- WAIT:
  - counter increments each cycle; start_o stays 1; opdata*/signed/mul_sel stay stable.
  - Selected ready=1 → latch result; start_o<=0, stallreq_o<=0, hilo_we_o<=1, go DONE.
  - HI/LO mapping: mul → hi=result[63:32], lo=result[31:0]; div → hi=remainder=result[63:32], lo=quotient=result[31:0].
  - The non-selected unit's ready is ignored.
- DONE (1 cycle):
  - hilo_we_o=1; next cycle hilo_we_o<=0, go IDLE.
  - The unit sees start=0 at this edge and returns to free.
  - op_valid_i in DONE belongs to the completed instruction and must NOT reissue.
- Flush:
  - flush_i=1 in WAIT → annul_o<=1, start_o<=0, stallreq_o<=0, no hilo_we, go RELEASE.
  - flush_i in IDLE → nothing issued.
  - flush_i in DONE → HI/LO write still completes (the instruction already committed its result).
- RELEASE (1 cycle):
  - annul_o<=0, start_o stays 0, go IDLE.
  - Guarantees the unit is free (in case ready arrived on the same edge as the flush).
- Simultaneous ready and flush in WAIT: flush wins; result discarded; no hilo_we.
- Watchdog: counter reaches TIMEOUT in WAIT with no ready → timeout_o<=1 (sticky until reset), annul pulse, stallreq drop, go RELEASE.
- Throughput: back-to-back ops need a minimum of 2 cycles between consecutive start_o rising edges after ready (DONE + IDLE).
- Reset mid-operation: immediate return to IDLE with all outputs 0; the unit is reset by the same rst.
- The controller performs no sign correction; the units handle it.

Test Plan:
- MULT src1=0xFFFFFFFE (-2), src2=3, mul ready after 34 cycles with result 0xFFFFFFFF_FFFFFFFA → signed_o=1, mul_sel_o=1, stall for 35 cycles, hilo_we 1 cycle with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU 100/7, div result {2,14} → signed_o=0, mul_sel_o=0, hi=2, lo=14; op_valid held in DONE causes no second start.
- MULTU issued, flush_i at WAIT cycle 10 → annul_o pulse exactly 1 cycle, start_o=0, no hilo_we; new MULT 3 cycles later issues normally.
- ready_i and flush_i in the same cycle → no hilo_we; RELEASE then IDLE.
- Unit never asserts ready → timeout_o=1 at cycle TIMEOUT=40 of WAIT, annul pulse, stall released, timeout_o stays 1.
- rst=0 in WAIT cycle 5 → next cycle all outputs 0, state IDLE; a new op after reset completes correctly.
